// File: rtl/u_rec_pkg.sv
// Shared UART receiver definitions: line levels, word length and FSM state encodings.
package u_rec_pkg;

  localparam logic HI = 1'b1;
  localparam logic LO = 1'b0;

  localparam int WORD_LEN = 8;
  localparam int BIT_W    = $clog2(WORD_LEN);

  // Cell counter terminal values: start bit is judged at half a cell, the rest at full cells.
  localparam logic [3:0] START_DEC = 4'd7;
  localparam logic [3:0] CELL_DEC  = 4'd15;

  typedef enum logic [2:0] {
    r_IDLE  = 3'd0,
    r_START = 3'd1,
    r_DATA  = 3'd2,
    r_STOP  = 3'd3
  } r_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/u_rec_sync.sv
// Two-flop synchronizer for the serial line plus a one-cycle-delayed copy for edge detection.
// rx_s_o lags the pin by 2 cycles; fall_o flags rx_s LO while the previous sample was HI.
module u_rec_sync
  import u_rec_pkg::*;
(
  input  logic sys_clk,
  input  logic sys_rst_l,
  input  logic rx_async_i,
  output logic rx_s_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Idle line is HI, so reset to HI to avoid a phantom start after reset.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      meta_q <= HI;
      sync_q <= HI;
      prev_q <= HI;
    end else begin
      meta_q <= rx_async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_s_o = sync_q;
  assign fall_o = (sync_q == LO) && (prev_q == HI);

endmodule

// File: rtl/u_rec.sv
// 8N1 UART receiver at 16 ticks per bit; byte/error pulse appears 154 cycles after the start-bit fall.
// Define RX_MAJORITY_EN to decide each bit by 2-of-3 vote over the last three ticks before the decision.
module u_rec
  import u_rec_pkg::*;
(
  input  logic       sys_clk,
  input  logic       sys_rst_l,
  input  logic       uart_recH,
  output logic [7:0] rec_dataH,
  output logic       rec_readyH,
  output logic       frame_errH,
  output logic       rec_busyH
);

  logic rx_s;
  logic rx_fall;

  u_rec_sync u_sync (
    .sys_clk    (sys_clk),
    .sys_rst_l  (sys_rst_l),
    .rx_async_i (uart_recH),
    .rx_s_o     (rx_s),
    .fall_o     (rx_fall)
  );

  r_state_t             state_q,  state_d;
  logic [3:0]           cntr_q,   cntr_d;
  logic [BIT_W-1:0]     bitcnt_q, bitcnt_d;
  logic [WORD_LEN-1:0]  shift_q,  shift_d;
  logic [WORD_LEN-1:0]  data_q,   data_d;
  logic                 ready_q,  ready_d;
  logic                 ferr_q,   ferr_d;
  logic                 busy_q,   busy_d;

  logic       sample;
  logic [3:0] dec_cnt;

  assign dec_cnt = (state_q == r_START) ? START_DEC : CELL_DEC;

`ifdef RX_MAJORITY_EN
  logic [1:0] vote_q;

  // Capture the two ticks preceding the decision; the third vote is the live sample.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      vote_q <= {HI, HI};
    end else begin
      if (cntr_q == dec_cnt - 4'd2) vote_q[0] <= rx_s;
      if (cntr_q == dec_cnt - 4'd1) vote_q[1] <= rx_s;
    end
  end

  assign sample = maj3(vote_q[0], vote_q[1], rx_s);
`else
  assign sample = rx_s;
`endif

  always_comb begin
    state_d  = state_q;
    cntr_d   = cntr_q + 4'd1;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    data_d   = data_q;
    ready_d  = 1'b0;
    ferr_d   = 1'b0;

    case (state_q)
      r_IDLE: begin
        cntr_d = 4'd0;
        if (rx_fall) state_d = r_START;
      end
      r_START: begin
        if (cntr_q == START_DEC) begin
          cntr_d   = 4'd0;
          bitcnt_d = '0;
          state_d  = (sample == LO) ? r_DATA : r_IDLE;
        end
      end
      r_DATA: begin
        if (cntr_q == CELL_DEC) begin
          cntr_d   = 4'd0;
          shift_d  = {sample, shift_q[WORD_LEN-1:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == BIT_W'(WORD_LEN - 1)) state_d = r_STOP;
        end
      end
      r_STOP: begin
        if (cntr_q == CELL_DEC) begin
          cntr_d  = 4'd0;
          state_d = r_IDLE;
          if (sample == HI) begin
            data_d  = shift_q;
            ready_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = r_IDLE;
        cntr_d  = 4'd0;
      end
    endcase

    busy_d = (state_d != r_IDLE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state_q  <= r_IDLE;
      cntr_q   <= 4'd0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      ready_q  <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cntr_q   <= cntr_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      ready_q  <= ready_d;
      ferr_q   <= ferr_d;
      busy_q   <= busy_d;
    end
  end

  assign rec_dataH  = data_q;
  assign rec_readyH = ready_q;
  assign frame_errH = ferr_q;
  assign rec_busyH  = busy_q;

endmodule

// File: tb/tb_u_rec.sv
// Scoreboard bench for u_rec: frames are driven tick by tick, expected pulses queued with their cycle stamp.
module tb_u_rec;

  logic       sys_clk;
  logic       sys_rst_l;
  logic       uart_recH;
  logic [7:0] rec_dataH;
  logic       rec_readyH;
  logic       frame_errH;
  logic       rec_busyH;

  u_rec dut (
    .sys_clk    (sys_clk),
    .sys_rst_l  (sys_rst_l),
    .uart_recH  (uart_recH),
    .rec_dataH  (rec_dataH),
    .rec_readyH (rec_readyH),
    .frame_errH (frame_errH),
    .rec_busyH  (rec_busyH)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        err;
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int unsigned cyc    = 0;
  logic [7:0]  last_good = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: sampled 1 time unit after each rising edge; cyc numbers the edges.
  always @(posedge sys_clk) begin
    exp_t e;
    #1;
    cyc++;
    if (rec_readyH || frame_errH) begin
      check("pulse_excl", {31'd0, rec_readyH & frame_errH}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", {31'd0, frame_errH}, {31'd0, e.err});
        check("rx_data",    {24'd0, rec_dataH},  {24'd0, e.data});
        check("pulse_time", cyc,                 e.cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      uart_recH = 1'b1;
    end
  endtask

  // Drives one 160-tick frame starting at the next negedge. Tick c is sampled at edge S+c.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch_c,
                            input int abort_c, input logic [7:0] exp_b);
    int unsigned s;
    exp_t        e;
    logic        v;
    @(negedge sys_clk);
    s = cyc + 1;
    if (abort_c < 0) begin
      e.err  = ~stop;
      e.data = stop ? exp_b : last_good;
      e.cyc  = s + 154;
      sb.push_back(e);
      if (stop) last_good = exp_b;
    end
    for (int c = 0; c < 160; c++) begin
      if (c > 0) @(negedge sys_clk);
      if (c == abort_c) return;
      if (c < 16)       v = 1'b0;
      else if (c < 144) v = b[(c - 16) / 16];
      else              v = stop;
      if (c == glitch_c) v = 1'b1;
      uart_recH = v;
    end
  endtask

  initial begin
    int unsigned s;
    logic [7:0]  glitch_exp;

    sys_rst_l = 1'b0;
    uart_recH = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("rst_data",  {24'd0, rec_dataH}, 32'd0);
    check("rst_ready", {31'd0, rec_readyH}, 32'd0);
    check("rst_ferr",  {31'd0, frame_errH}, 32'd0);
    check("rst_busy",  {31'd0, rec_busyH},  32'd0);
    sys_rst_l = 1'b1;
    idle(10);

    send_frame(8'hA5, 1'b1, -1, -1, 8'hA5);
    idle(20);

    // Short LO glitch: start decision at S+10 sees HI again.
    @(negedge sys_clk);
    s = cyc + 1;
    uart_recH = 1'b0;
    repeat (3) @(negedge sys_clk);
    @(negedge sys_clk);
    uart_recH = 1'b1;
    while (cyc < s + 9) @(negedge sys_clk);
    check("glitch_busy_hi", {31'd0, rec_busyH}, 32'd1);
    @(negedge sys_clk);
    check("glitch_busy_lo", {31'd0, rec_busyH}, 32'd0);
    idle(20);

    // Bad stop bit, then a held-LO line that must not start a frame.
    send_frame(8'h3C, 1'b0, -1, -1, 8'h3C);
    repeat (300) begin
      @(negedge sys_clk);
      uart_recH = 1'b0;
    end
    check("break_busy", {31'd0, rec_busyH}, 32'd0);
    idle(40);

    send_frame(8'h00, 1'b1, -1, -1, 8'h00);
    send_frame(8'hFF, 1'b1, -1, -1, 8'hFF);
    send_frame(8'h55, 1'b1, -1, -1, 8'h55);
    idle(20);

    // Reset in the middle of data bit 3.
    send_frame(8'h81, 1'b1, -1, 72, 8'h81);
    @(negedge sys_clk);
    sys_rst_l = 1'b0;
    uart_recH = 1'b1;
    @(negedge sys_clk);
    check("midrst_data", {24'd0, rec_dataH}, 32'd0);
    check("midrst_busy", {31'd0, rec_busyH}, 32'd0);
    last_good = 8'h00;
    repeat (2) @(negedge sys_clk);
    sys_rst_l = 1'b1;
    idle(10);
    send_frame(8'h7E, 1'b1, -1, -1, 8'h7E);
    idle(20);

`ifdef RX_MAJORITY_EN
    glitch_exp = 8'h00;
`else
    glitch_exp = 8'h04;
`endif
    send_frame(8'h00, 1'b1, 56, -1, glitch_exp);
    idle(200);

    check("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
